// File: rtl/fib_s2mm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fib_s2mm_gen
//  Description : S2MM traffic generator for the AXI DataMover write path.
//                Issues NUM_SEG write commands, each followed by a burst of
//                BEATS_PER_SEG beats carrying a Fibonacci or counter pattern
//                computed on the fly.
//  Revision    : 1.0 - initial release
// ============================================================================
module fib_s2mm_gen #(
    parameter int                DATA_W        = 256,
    parameter int                ADDR_W        = 64,
    parameter int                NUM_SEG       = 2,
    parameter int                BEATS_PER_SEG = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = 64'h0A00_0000,
    parameter logic [ADDR_W-1:0] SEG_STRIDE    = 64'h0010_0000,
    parameter int                CMD_GAP       = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ap_start,
    input  logic                  pattern_sel,
    output logic                  ap_idle,
    output logic                  ap_done,
    output logic                  s_axis_s2mm_cmd_tvalid,
    input  logic                  s_axis_s2mm_cmd_tready,
    output logic [ADDR_W+39:0]    s_axis_s2mm_cmd_tdata,
    output logic                  s_axis_s2mm_tvalid,
    input  logic                  s_axis_s2mm_tready,
    output logic [DATA_W-1:0]     s_axis_s2mm_tdata,
    output logic [DATA_W/8-1:0]   s_axis_s2mm_tkeep,
    output logic                  s_axis_s2mm_tlast
);

    localparam int c_keep_w = DATA_W / 8;
    localparam int c_beat_w = (BEATS_PER_SEG > 1) ? $clog2(BEATS_PER_SEG) : 1;
    localparam int c_gap_w  = (CMD_GAP > 1) ? $clog2(CMD_GAP) : 1;

    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(BEATS_PER_SEG - 1);
    localparam logic [c_gap_w-1:0]  c_last_gap  = c_gap_w'((CMD_GAP > 0) ? CMD_GAP - 1 : 0);
    localparam logic [3:0]          c_last_seg  = 4'(NUM_SEG - 1);
    localparam logic [22:0]         c_btt       = 23'(BEATS_PER_SEG * DATA_W / 8);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_cmd  = 3'd1;
    localparam logic [2:0] c_st_gap  = 3'd2;
    localparam logic [2:0] c_st_data = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

    // Command word: reserved nibble, tag, address, type/DSA byte, EOF, BTT.
    function automatic logic [ADDR_W+39:0] f_cmd_word(input logic [3:0]        seg,
                                                      input logic [ADDR_W-1:0] addr);
        return {4'h0, seg, addr, 8'h40, 1'b1, c_btt};
    endfunction

    logic [2:0]            r_state,        w_state_nxt;
    logic [3:0]            r_seg,          w_seg_nxt;
    logic [c_beat_w-1:0]   r_beat,         w_beat_nxt;
    logic [c_gap_w-1:0]    r_gap,          w_gap_nxt;
    logic [ADDR_W-1:0]     r_addr,         w_addr_nxt;
    logic [DATA_W-1:0]     r_a,            w_a_nxt;
    logic [DATA_W-1:0]     r_b,            w_b_nxt;
    logic                  r_mode,         w_mode_nxt;
    logic                  r_cmd_tvalid,   w_cmd_tvalid_nxt;
    logic [ADDR_W+39:0]    r_cmd_tdata,    w_cmd_tdata_nxt;
    logic                  r_tvalid,       w_tvalid_nxt;
    logic [DATA_W-1:0]     r_tdata,        w_tdata_nxt;
    logic [c_keep_w-1:0]   r_tkeep,        w_tkeep_nxt;
    logic                  r_tlast,        w_tlast_nxt;
    logic                  r_ap_idle,      w_ap_idle_nxt;
    logic                  r_ap_done,      w_ap_done_nxt;

    logic                  w_cmd_hs;
    logic                  w_data_hs;
    logic [DATA_W-1:0]     w_a_step;
    logic [DATA_W-1:0]     w_b_step;
    logic [c_beat_w-1:0]   w_beat_inc;
    logic [3:0]            w_seg_inc;
    logic [ADDR_W-1:0]     w_addr_inc;

    assign w_cmd_hs   = r_cmd_tvalid & s_axis_s2mm_cmd_tready;
    assign w_data_hs  = r_tvalid & s_axis_s2mm_tready;
    // Pattern step: counter adds one, Fibonacci shifts the (A,B) pair forward.
    assign w_a_step   = r_mode ? (r_a + DATA_W'(1)) : r_b;
    assign w_b_step   = r_a + r_b;
    assign w_beat_inc = r_beat + c_beat_w'(1);
    assign w_seg_inc  = r_seg + 4'd1;
    assign w_addr_inc = r_addr + SEG_STRIDE;

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        w_state_nxt      = r_state;
        w_seg_nxt        = r_seg;
        w_beat_nxt       = r_beat;
        w_gap_nxt        = r_gap;
        w_addr_nxt       = r_addr;
        w_a_nxt          = r_a;
        w_b_nxt          = r_b;
        w_mode_nxt       = r_mode;
        w_cmd_tvalid_nxt = r_cmd_tvalid;
        w_cmd_tdata_nxt  = r_cmd_tdata;
        w_tvalid_nxt     = r_tvalid;
        w_tdata_nxt      = r_tdata;
        w_tkeep_nxt      = r_tkeep;
        w_tlast_nxt      = r_tlast;
        w_ap_idle_nxt    = r_ap_idle;
        w_ap_done_nxt    = r_ap_done;

        case (r_state)
            c_st_idle: begin
                if (ap_start) begin
                    w_mode_nxt       = pattern_sel;
                    w_seg_nxt        = 4'd0;
                    w_beat_nxt       = '0;
                    w_addr_nxt       = BASE_ADDR;
                    w_a_nxt          = '0;
                    w_b_nxt          = DATA_W'(1);
                    w_state_nxt      = c_st_cmd;
                    w_cmd_tvalid_nxt = 1'b1;
                    w_cmd_tdata_nxt  = f_cmd_word(4'd0, BASE_ADDR);
                    w_ap_idle_nxt    = 1'b0;
                end
            end

            c_st_cmd: begin
                if (w_cmd_hs) begin
                    w_cmd_tvalid_nxt = 1'b0;
                    w_cmd_tdata_nxt  = '0;
                    w_gap_nxt        = '0;
                    if (CMD_GAP == 0) begin
                        // No gap: the first beat is presented right after the handshake.
                        w_state_nxt  = c_st_data;
                        w_tvalid_nxt = 1'b1;
                        w_tdata_nxt  = r_a;
                        w_tkeep_nxt  = '1;
                        w_tlast_nxt  = (r_beat == c_last_beat);
                    end else begin
                        w_state_nxt  = c_st_gap;
                    end
                end
            end

            c_st_gap: begin
                if (r_gap == c_last_gap) begin
                    w_state_nxt  = c_st_data;
                    w_tvalid_nxt = 1'b1;
                    w_tdata_nxt  = r_a;
                    w_tkeep_nxt  = '1;
                    w_tlast_nxt  = (r_beat == c_last_beat);
                end else begin
                    w_gap_nxt    = r_gap + c_gap_w'(1);
                end
            end

            c_st_data: begin
                if (w_data_hs) begin
                    w_a_nxt = w_a_step;
                    w_b_nxt = w_b_step;
                    if (r_tlast) begin
                        w_beat_nxt   = '0;
                        w_tvalid_nxt = 1'b0;
                        w_tlast_nxt  = 1'b0;
                        if (r_seg == c_last_seg) begin
                            w_state_nxt   = c_st_done;
                            w_ap_done_nxt = 1'b1;
                        end else begin
                            w_seg_nxt        = w_seg_inc;
                            w_addr_nxt       = w_addr_inc;
                            w_state_nxt      = c_st_cmd;
                            w_cmd_tvalid_nxt = 1'b1;
                            w_cmd_tdata_nxt  = f_cmd_word(w_seg_inc, w_addr_inc);
                        end
                    end else begin
                        w_beat_nxt  = w_beat_inc;
                        w_tdata_nxt = w_a_step;
                        w_tlast_nxt = (w_beat_inc == c_last_beat);
                    end
                end
            end

            c_st_done: begin
                // Held here until ap_start drops, so a level start cannot re-trigger.
                if (!ap_start) begin
                    w_state_nxt   = c_st_idle;
                    w_ap_done_nxt = 1'b0;
                    w_ap_idle_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt      = c_st_idle;
                w_cmd_tvalid_nxt = 1'b0;
                w_tvalid_nxt     = 1'b0;
                w_ap_done_nxt    = 1'b0;
                w_ap_idle_nxt    = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_seg        <= '0;
            r_beat       <= '0;
            r_gap        <= '0;
            r_addr       <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_mode       <= 1'b0;
            r_cmd_tvalid <= 1'b0;
            r_cmd_tdata  <= '0;
            r_tvalid     <= 1'b0;
            r_tdata      <= '0;
            r_tkeep      <= '0;
            r_tlast      <= 1'b0;
            r_ap_idle    <= 1'b1;
            r_ap_done    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_seg        <= w_seg_nxt;
            r_beat       <= w_beat_nxt;
            r_gap        <= w_gap_nxt;
            r_addr       <= w_addr_nxt;
            r_a          <= w_a_nxt;
            r_b          <= w_b_nxt;
            r_mode       <= w_mode_nxt;
            r_cmd_tvalid <= w_cmd_tvalid_nxt;
            r_cmd_tdata  <= w_cmd_tdata_nxt;
            r_tvalid     <= w_tvalid_nxt;
            r_tdata      <= w_tdata_nxt;
            r_tkeep      <= w_tkeep_nxt;
            r_tlast      <= w_tlast_nxt;
            r_ap_idle    <= w_ap_idle_nxt;
            r_ap_done    <= w_ap_done_nxt;
        end
    end

    assign ap_idle                = r_ap_idle;
    assign ap_done                = r_ap_done;
    assign s_axis_s2mm_cmd_tvalid = r_cmd_tvalid;
    assign s_axis_s2mm_cmd_tdata  = r_cmd_tdata;
    assign s_axis_s2mm_tvalid     = r_tvalid;
    assign s_axis_s2mm_tdata      = r_tdata;
    assign s_axis_s2mm_tkeep      = r_tkeep;
    assign s_axis_s2mm_tlast      = r_tlast;

endmodule
`default_nettype wire

// File: tb/tb_fib_s2mm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fib_s2mm_gen
//  Description : Self-checking bench for fib_s2mm_gen. Three instances:
//                d0 default geometry, d1 8-bit single segment with no gap,
//                d2 32-bit three segments with a short gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_s2mm_gen;

    logic clk;
    logic rst;
    logic start  [3];
    logic psel   [3];
    logic ctr    [3];
    logic tr     [3];

    logic         d0_idle, d0_done, d0_ctv, d0_tv, d0_tl;
    logic [103:0] d0_ctd;
    logic [255:0] d0_td;
    logic [31:0]  d0_tk;
    logic         d1_idle, d1_done, d1_ctv, d1_tv, d1_tl;
    logic [103:0] d1_ctd;
    logic [7:0]   d1_td;
    logic [0:0]   d1_tk;
    logic         d2_idle, d2_done, d2_ctv, d2_tv, d2_tl;
    logic [103:0] d2_ctd;
    logic [31:0]  d2_td;
    logic [3:0]   d2_tk;

    logic         m_idle [3];
    logic         m_done [3];
    logic         m_ctv  [3];
    logic         m_tv   [3];
    logic         m_tl   [3];
    logic [103:0] m_ctd  [3];
    logic [255:0] m_td   [3];
    logic [31:0]  m_tk   [3];

    int total;
    int bad;
    logic [103:0] cmd_q  [$];
    logic [255:0] beat_q [$];
    bit           last_q [$];
    int           hs_q   [$];
    int           fv_q   [$];
    int           stall_seen;
    bit           run_done;

    fib_s2mm_gen dut0 (
        .clk(clk), .rst(rst), .ap_start(start[0]), .pattern_sel(psel[0]),
        .ap_idle(d0_idle), .ap_done(d0_done),
        .s_axis_s2mm_cmd_tvalid(d0_ctv), .s_axis_s2mm_cmd_tready(ctr[0]),
        .s_axis_s2mm_cmd_tdata(d0_ctd),
        .s_axis_s2mm_tvalid(d0_tv), .s_axis_s2mm_tready(tr[0]),
        .s_axis_s2mm_tdata(d0_td), .s_axis_s2mm_tkeep(d0_tk), .s_axis_s2mm_tlast(d0_tl)
    );

    fib_s2mm_gen #(.DATA_W(8), .NUM_SEG(1), .BEATS_PER_SEG(16), .CMD_GAP(0)) dut1 (
        .clk(clk), .rst(rst), .ap_start(start[1]), .pattern_sel(psel[1]),
        .ap_idle(d1_idle), .ap_done(d1_done),
        .s_axis_s2mm_cmd_tvalid(d1_ctv), .s_axis_s2mm_cmd_tready(ctr[1]),
        .s_axis_s2mm_cmd_tdata(d1_ctd),
        .s_axis_s2mm_tvalid(d1_tv), .s_axis_s2mm_tready(tr[1]),
        .s_axis_s2mm_tdata(d1_td), .s_axis_s2mm_tkeep(d1_tk), .s_axis_s2mm_tlast(d1_tl)
    );

    fib_s2mm_gen #(.DATA_W(32), .NUM_SEG(3), .BEATS_PER_SEG(4), .CMD_GAP(3)) dut2 (
        .clk(clk), .rst(rst), .ap_start(start[2]), .pattern_sel(psel[2]),
        .ap_idle(d2_idle), .ap_done(d2_done),
        .s_axis_s2mm_cmd_tvalid(d2_ctv), .s_axis_s2mm_cmd_tready(ctr[2]),
        .s_axis_s2mm_cmd_tdata(d2_ctd),
        .s_axis_s2mm_tvalid(d2_tv), .s_axis_s2mm_tready(tr[2]),
        .s_axis_s2mm_tdata(d2_td), .s_axis_s2mm_tkeep(d2_tk), .s_axis_s2mm_tlast(d2_tl)
    );

    // Uniform view of the three instances, data zero-extended.
    always_comb begin
        m_idle[0] = d0_idle; m_done[0] = d0_done; m_ctv[0] = d0_ctv; m_tv[0] = d0_tv; m_tl[0] = d0_tl;
        m_ctd[0]  = d0_ctd;  m_td[0] = d0_td;                     m_tk[0] = d0_tk;
        m_idle[1] = d1_idle; m_done[1] = d1_done; m_ctv[1] = d1_ctv; m_tv[1] = d1_tv; m_tl[1] = d1_tl;
        m_ctd[1]  = d1_ctd;  m_td[1] = {248'b0, d1_td};           m_tk[1] = {31'b0, d1_tk};
        m_idle[2] = d2_idle; m_done[2] = d2_done; m_ctv[2] = d2_ctv; m_tv[2] = d2_tv; m_tl[2] = d2_tl;
        m_ctd[2]  = d2_ctd;  m_td[2] = {224'b0, d2_td};           m_tk[2] = {28'b0, d2_tk};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: k-th value of the run's pattern, modulo 2^w.
    function automatic logic [255:0] ref_beat(input bit pat, input int k, input int w);
        logic [255:0] a, b, t, mask;
        mask = (256'd1 << w) - 256'd1;
        a = '0;
        b = 256'd1;
        for (int i = 0; i < k; i++) begin
            if (pat) begin
                a = (a + 256'd1) & mask;
            end else begin
                t = (a + b) & mask;
                a = b;
                b = t;
            end
        end
        return a;
    endfunction

    // Reference command word for segment s (default base/stride, 64-bit address).
    function automatic logic [103:0] ref_cmd(input int s, input int btt);
        logic [63:0] addr;
        addr = 64'h0A00_0000 + 64'(s) * 64'h0010_0000;
        return {4'h0, 4'(s), addr, 8'h40, 1'b1, 23'(btt)};
    endfunction

    function automatic logic [31:0] keep_of(input int d);
        return (d == 0) ? 32'hFFFF_FFFF : (d == 1) ? 32'h1 : 32'hF;
    endfunction

    // One run on instance d: records commands, beats and latencies, checks
    // hold stability under backpressure and command stall as it goes.
    task automatic run_seq(input int d, input bit pat, input int pct, input int hold, input int abort_at);
        int n, stall;
        bit waiting, pend, aborted;
        logic [255:0] pdata;
        logic plast;
        logic [103:0] held;
        cmd_q.delete(); beat_q.delete(); last_q.delete(); hs_q.delete(); fv_q.delete();
        n = 0; stall = 0; waiting = 0; pend = 0; aborted = 0; run_done = 0;
        held = '0; pdata = '0; plast = 1'b0;
        @(negedge clk);
        psel[d]  = pat;
        start[d] = 1'b1;
        ctr[d]   = 1'b0;
        tr[d]    = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n++;
            psel[d] = 1'($urandom_range(0, 1));
            if (n == 1) begin
                total++;
                if (m_ctv[d] !== 1'b1) begin
                    bad++;
                    $display("FAIL cmd_rise d%0d: cmd_tvalid=%b want 1", d, m_ctv[d]);
                end
            end
            if (cmd_q.size() == 0 && stall < hold && (stall > 0 || m_ctv[d] === 1'b1)) begin
                ctr[d] = 1'b0;
                if (stall == 0) held = m_ctd[d];
                else begin
                    total++;
                    if (m_ctv[d] !== 1'b1 || m_ctd[d] !== held) begin
                        bad++;
                        $display("FAIL cmd_hold d%0d: valid=%b data=%h want 1 %h", d, m_ctv[d], m_ctd[d], held);
                    end
                end
                stall++;
            end else begin
                ctr[d] = 1'b1;
            end
            tr[d] = ($urandom_range(0, 99) < pct);
            if (pend) begin
                total++;
                if (m_tv[d] !== 1'b1 || m_td[d] !== pdata || m_tl[d] !== plast) begin
                    bad++;
                    $display("FAIL data_hold d%0d: v=%b d=%h l=%b want 1 %h %b", d, m_tv[d], m_td[d], m_tl[d], pdata, plast);
                end
            end
            if (m_tv[d] === 1'b1) begin
                total++;
                if (m_tk[d] !== keep_of(d)) begin
                    bad++;
                    $display("FAIL tkeep d%0d: got %h want %h", d, m_tk[d], keep_of(d));
                end
            end
            if (m_ctv[d] === 1'b1 && ctr[d]) begin
                cmd_q.push_back(m_ctd[d]);
                hs_q.push_back(n);
                waiting = 1;
            end else if (waiting && m_tv[d] === 1'b1) begin
                fv_q.push_back(n);
                waiting = 0;
            end
            pend  = (m_tv[d] === 1'b1) && !tr[d];
            pdata = m_td[d];
            plast = m_tl[d];
            if (m_tv[d] === 1'b1 && tr[d]) begin
                beat_q.push_back(m_td[d]);
                last_q.push_back(m_tl[d] === 1'b1);
                if (abort_at > 0 && beat_q.size() == abort_at) begin
                    aborted = 1;
                    break;
                end
            end
            if (m_done[d] === 1'b1) begin
                run_done = 1;
                break;
            end
        end
        stall_seen = stall;
        if (!run_done && !aborted) begin
            total++;
            bad++;
            $display("FAIL timeout d%0d: beats=%0d cmds=%0d", d, beat_q.size(), cmd_q.size());
        end
    endtask

    task automatic end_run(input int d);
        start[d] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            total++;
            if ({m_idle[d], m_done[d], m_ctv[d], m_tv[d], m_tl[d]} !== 5'b10000) begin
                bad++;
                $display("FAIL reset_flags d%0d: got %b want 10000", d, {m_idle[d], m_done[d], m_ctv[d], m_tv[d], m_tl[d]});
            end
            total++;
            if (m_td[d] !== '0 || m_ctd[d] !== '0 || m_tk[d] !== '0) begin
                bad++;
                $display("FAIL reset_data d%0d: td=%h ctd=%h tk=%h want 0", d, m_td[d], m_ctd[d], m_tk[d]);
            end
        end
    endtask

    task automatic test_fib_default();
        run_seq(0, 1'b0, 100, 0, 0);
        total++;
        if (cmd_q.size() != 2) begin bad++; $display("FAIL fib_cmd_count: got %0d want 2", cmd_q.size()); end
        for (int s = 0; s < cmd_q.size() && s < 2; s++) begin
            total++;
            if (cmd_q[s] !== ref_cmd(s, 256)) begin bad++; $display("FAIL fib_cmd%0d: got %h want %h", s, cmd_q[s], ref_cmd(s, 256)); end
        end
        total++;
        if (beat_q.size() != 16) begin bad++; $display("FAIL fib_beat_count: got %0d want 16", beat_q.size()); end
        for (int k = 0; k < beat_q.size() && k < 16; k++) begin
            total++;
            if (beat_q[k] !== ref_beat(1'b0, k, 256) || last_q[k] != (k % 8 == 7)) begin
                bad++;
                $display("FAIL fib_beat%0d: got %0d last=%b want %0d last=%b", k, beat_q[k], last_q[k], ref_beat(1'b0, k, 256), (k % 8 == 7));
            end
        end
        total++;
        if (fv_q.size() != 2) begin bad++; $display("FAIL fib_bursts: got %0d want 2", fv_q.size()); end
        for (int s = 0; s < fv_q.size(); s++) begin
            total++;
            if (fv_q[s] - hs_q[s] != 11) begin bad++; $display("FAIL fib_gap%0d: got %0d want 11", s, fv_q[s] - hs_q[s]); end
        end
        repeat (4) begin
            @(negedge clk);
            total++;
            if ({m_done[0], m_idle[0], m_tv[0], m_ctv[0]} !== 4'b1000) begin
                bad++;
                $display("FAIL done_hold: got %b want 1000", {m_done[0], m_idle[0], m_tv[0], m_ctv[0]});
            end
        end
        start[0] = 1'b0;
        @(negedge clk);
        total++;
        if ({m_idle[0], m_done[0]} !== 2'b10) begin bad++; $display("FAIL done_exit: got %b want 10", {m_idle[0], m_done[0]}); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        run_seq(0, 1'b0, 50, 0, 0);
        total++;
        if (beat_q.size() != 16) begin bad++; $display("FAIL bp_beat_count: got %0d want 16", beat_q.size()); end
        for (int k = 0; k < beat_q.size() && k < 16; k++) begin
            total++;
            if (beat_q[k] !== ref_beat(1'b0, k, 256) || last_q[k] != (k % 8 == 7)) begin
                bad++;
                $display("FAIL bp_beat%0d: got %0d last=%b want %0d", k, beat_q[k], last_q[k], ref_beat(1'b0, k, 256));
            end
        end
        end_run(0);
    endtask

    task automatic test_cmd_stall();
        run_seq(0, 1'b0, 100, 20, 0);
        total++;
        if (stall_seen != 20) begin bad++; $display("FAIL stall_len: got %0d want 20", stall_seen); end
        total++;
        if (cmd_q.size() < 1 || cmd_q[0] !== ref_cmd(0, 256)) begin bad++; $display("FAIL stall_cmd0: count=%0d", cmd_q.size()); end
        for (int s = 0; s < fv_q.size(); s++) begin
            total++;
            if (fv_q[s] - hs_q[s] != 11) begin bad++; $display("FAIL stall_gap%0d: got %0d want 11", s, fv_q[s] - hs_q[s]); end
        end
        end_run(0);
    endtask

    task automatic test_w8();
        run_seq(1, 1'b0, 100, 0, 0);
        total++;
        if (cmd_q.size() != 1 || cmd_q[0] !== ref_cmd(0, 16)) begin bad++; $display("FAIL w8_cmd: count=%0d want 1 with btt 16", cmd_q.size()); end
        total++;
        if (beat_q.size() != 16) begin bad++; $display("FAIL w8_beat_count: got %0d want 16", beat_q.size()); end
        for (int k = 0; k < beat_q.size() && k < 16; k++) begin
            total++;
            if (beat_q[k] !== ref_beat(1'b0, k, 8) || last_q[k] != (k == 15)) begin
                bad++;
                $display("FAIL w8_beat%0d: got %0d last=%b want %0d", k, beat_q[k], last_q[k], ref_beat(1'b0, k, 8));
            end
        end
        total++;
        if (beat_q.size() == 16 && (beat_q[13] !== 256'd233 || beat_q[14] !== 256'd121 || beat_q[15] !== 256'd98)) begin
            bad++;
            $display("FAIL w8_wrap: got %0d %0d %0d want 233 121 98", beat_q[13], beat_q[14], beat_q[15]);
        end
        total++;
        if (fv_q.size() != 1 || fv_q[0] - hs_q[0] != 1) begin bad++; $display("FAIL w8_gap: bursts=%0d want latency 1", fv_q.size()); end
        end_run(1);
    endtask

    task automatic test_counter();
        run_seq(2, 1'b1, 60, 0, 0);
        total++;
        if (cmd_q.size() != 3) begin bad++; $display("FAIL cnt_cmd_count: got %0d want 3", cmd_q.size()); end
        for (int s = 0; s < cmd_q.size() && s < 3; s++) begin
            total++;
            if (cmd_q[s] !== ref_cmd(s, 16)) begin bad++; $display("FAIL cnt_cmd%0d: got %h want %h", s, cmd_q[s], ref_cmd(s, 16)); end
        end
        total++;
        if (beat_q.size() != 12) begin bad++; $display("FAIL cnt_beat_count: got %0d want 12", beat_q.size()); end
        for (int k = 0; k < beat_q.size() && k < 12; k++) begin
            total++;
            if (beat_q[k] !== ref_beat(1'b1, k, 32) || last_q[k] != (k % 4 == 3)) begin
                bad++;
                $display("FAIL cnt_beat%0d: got %0d last=%b want %0d", k, beat_q[k], last_q[k], ref_beat(1'b1, k, 32));
            end
        end
        for (int s = 0; s < fv_q.size(); s++) begin
            total++;
            if (fv_q[s] - hs_q[s] != 4) begin bad++; $display("FAIL cnt_gap%0d: got %0d want 4", s, fv_q[s] - hs_q[s]); end
        end
        end_run(2);
    endtask

    task automatic test_reset_mid();
        run_seq(0, 1'b0, 100, 0, 14);
        total++;
        if (beat_q.size() != 14) begin bad++; $display("FAIL mid_abort: got %0d beats want 14", beat_q.size()); end
        @(negedge clk);
        rst      = 1'b1;
        start[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({m_idle[0], m_done[0], m_ctv[0], m_tv[0], m_tl[0]} !== 5'b10000 ||
            m_td[0] !== '0 || m_ctd[0] !== '0 || m_tk[0] !== '0) begin
            bad++;
            $display("FAIL mid_reset: flags=%b td=%h ctd=%h", {m_idle[0], m_done[0], m_ctv[0], m_tv[0], m_tl[0]}, m_td[0], m_ctd[0]);
        end
        run_seq(0, 1'b0, 70, 0, 0);
        total++;
        if (cmd_q.size() < 1 || cmd_q[0] !== ref_cmd(0, 256)) begin bad++; $display("FAIL mid_restart_cmd: count=%0d", cmd_q.size()); end
        total++;
        if (beat_q.size() != 16) begin bad++; $display("FAIL mid_beat_count: got %0d want 16", beat_q.size()); end
        for (int k = 0; k < beat_q.size() && k < 16; k++) begin
            total++;
            if (beat_q[k] !== ref_beat(1'b0, k, 256)) begin
                bad++;
                $display("FAIL mid_beat%0d: got %0d want %0d", k, beat_q[k], ref_beat(1'b0, k, 256));
            end
        end
        end_run(0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start[d] = 1'b0;
            psel[d]  = 1'b0;
            ctr[d]   = 1'b0;
            tr[d]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_fib_default();
        test_backpressure();
        test_cmd_stall();
        test_w8();
        test_counter();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fib_s2mm_gen.md
Name: fib_s2mm_gen

Overview:
- Parametrised S2MM traffic generator driving the AXI DataMover write path: command stream plus data stream.
- On start it issues NUM_SEG write commands, one per segment, each followed by a burst of BEATS_PER_SEG data beats carrying a Fibonacci or counter pattern. The pattern is computed on the fly; there is no memory array.
- Replaces the fixed two-command, 256-bit, 25-entry generator with full valid/ready compliance, run-time pattern selection and parametrised geometry.

Parameters:
- DATA_W, 256, data beat width in bits; a multiple of 8, at least 8.
- ADDR_W, 64, address field width inside the command word.
- NUM_SEG, 2, number of command+burst segments per run; range 1..16.
- BEATS_PER_SEG, 8, beats per segment; at least 1. BEATS_PER_SEG*DATA_W/8 must be below 2^23.
- BASE_ADDR, 64'h0A00_0000, address of segment 0.
- SEG_STRIDE, 64'h0010_0000, address increment per segment.
- CMD_GAP, 10, idle cycles between command acceptance and the first data beat; 0 is allowed.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ap_start  in  1  level request; sampled only in IDLE.
- pattern_sel  in  1  0 = Fibonacci, 1 = incrementing counter; latched at start.
- ap_idle  out  1  high in IDLE.
- ap_done  out  1  high in DONE.
- s_axis_s2mm_cmd_tvalid  out  1  command valid.
- s_axis_s2mm_cmd_tready  in  1  command ready.
- s_axis_s2mm_cmd_tdata  out  ADDR_W+40  command word.
- s_axis_s2mm_tvalid  out  1  data valid.
- s_axis_s2mm_tready  in  1  data ready.
- s_axis_s2mm_tdata  out  DATA_W  data beat.
- s_axis_s2mm_tkeep  out  DATA_W/8  byte enables.
- s_axis_s2mm_tlast  out  1  last beat of segment.

Behaviour:
- All outputs are registered.
- Reset values: all valids, tlast, tdata, cmd_tdata, tkeep and ap_done are 0; ap_idle is 1; state is IDLE; all counters are 0.
- Reset asserted in any state returns to these values on the next edge. Any in-flight transfer is abandoned with no completion.
- Handshake rules:
  - A transfer occurs on a cycle where valid and ready are both high.
  - Once a valid is raised, it and its data/tlast stay stable until the transfer.
  - Valid never depends combinationally on ready.
- States: IDLE, CMD, GAP, DATA, DONE.
- IDLE:
  - If ap_start is high: latch pattern_sel, set seg=0, beat=0, A=0, B=1 (counter mode: A=0), then go to CMD.
  - The move to CMD is registered, so cmd_tvalid rises the cycle after ap_start is sampled.
- CMD:
  - cmd_tvalid=1.
  - cmd_tdata = {4'h0, seg[3:0], BASE_ADDR+seg*SEG_STRIDE (ADDR_W bits, wrapping), 8'h40, 1'b1, BTT[22:0]}, where BTT = BEATS_PER_SEG*DATA_W/8.
  - On cmd handshake: cmd_tvalid drops the next cycle, cmd_tdata clears to 0, and the state goes to GAP (or to DATA directly if CMD_GAP=0).
- GAP:
  - Counts CMD_GAP cycles, then goes to DATA. The first beat is valid exactly CMD_GAP+1 cycles after the cmd handshake cycle.
- DATA:
  - tvalid=1, tdata=A, tkeep all ones, tlast = (beat==BEATS_PER_SEG-1).
  - On data handshake:
    - Fibonacci mode: A<=B, B<=A+B, computed modulo 2^DATA_W.
    - Counter mode: A<=A+1, modulo 2^DATA_W.
    - beat increments.
  - The next beat is presented the cycle after a handshake, so sustained tready gives one beat per cycle.
  - On a handshake with tlast=1:
    - beat resets to 0.
    - If seg<NUM_SEG-1: seg increments and the state goes to CMD (tvalid and tlast drop).
    - Otherwise the state goes to DONE.
- The pattern runs continuously across segment boundaries and restarts only at a new run.
- DONE:
  - ap_done=1 and all valids are 0.
  - Stays in DONE while ap_start is high. When ap_start is low, go to IDLE (ap_done=0, ap_idle=1).
  - A new run therefore requires ap_start to deassert and reassert.
- Boundary conditions:
  - tready low in DATA holds the current beat indefinitely.
  - cmd_tready low holds the command indefinitely.
  - With BEATS_PER_SEG=1, tlast=1 on every beat.
  - With NUM_SEG=1, the state goes to DONE after the first burst.
  - ap_start and pattern_sel are ignored outside IDLE/DONE.

Test Plan:
- Default parameters, pattern_sel=0, ap_start held high, both readies tied high -> cmd0 = {8'h00, 64'h0A00_0000, 8'h40, 1'b1, 23'd256}; first beat 11 cycles after the cmd handshake; seg0 beats 0,1,1,2,3,5,8,13 with tlast on 13; cmd1 addr 64'h0A10_0000 with tag 1; seg1 beats 21,34,55,89,144,233,377,610 with tlast on 610; ap_done stays high until ap_start drops, then ap_idle=1.
- Random tready backpressure (about 50% duty) -> tdata/tlast stable while tvalid && !tready; same 16-value sequence; no beat dropped or duplicated; scoreboard against a reference model.
- cmd_tready held low for 20 cycles in CMD -> cmd_tvalid and cmd_tdata constant for all 20 cycles; GAP starts only after the handshake.
- DATA_W=8, NUM_SEG=1, BEATS_PER_SEG=16, CMD_GAP=0 -> BTT=16; beat 13 = 233, beat 14 = 121 (377 mod 256), beat 15 = 98; first beat appears the cycle after the cmd handshake.
- pattern_sel=1, NUM_SEG=3, BEATS_PER_SEG=4 -> beats 0..11, tlast on beats 3, 7 and 11; tags 0,1,2; addresses base, base+stride, base+2*stride.
- rst pulsed for 1 cycle mid-burst (beat 5 of seg1), then ap_start again -> all outputs at reset values the cycle after rst; the new run restarts at seg0, beat value 0.
